// File: rtl/life_gen_engine_pkg.sv
// Shared constants, state encoding and cell helpers for the Game of Life generation engine.
package life_pkg;

    localparam int BIT_W = 3;
    localparam int BIT_H = 3;
    localparam int SIZE = 1 << (BIT_W + BIT_H);
    localparam logic [63:0] INIT_PATTERN = 64'h50A8_8888_0609_0909;
    localparam int INIT_POP = 17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    function automatic logic life_rule(input logic alive, input logic [3:0] n);
        logic r;
        if (alive) begin
            r = (n == 4'd2) || (n == 4'd3);
        end else begin
            r = (n == 4'd3);
        end
        return r;
    endfunction

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < 64; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/life_gen_engine_if.sv
// Control, edit, renderer-read and status signals of the generation engine.
interface life_gen_engine_if #(
    parameter int BIT_W = 3,
    parameter int BIT_H = 3
);
    localparam int AW = BIT_W + BIT_H;

    logic          frame_tick;
    logic          run;
    logic          step;
    logic [1:0]    frame_div;
    logic          load;
    logic          clear;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic [AW-1:0] rd_addr;
    logic          rd_data;
    logic          busy;
    logic [15:0]   gen_count;
    logic [AW:0]   pop_count;

    modport master (
        output frame_tick, run, step, frame_div, load, clear,
               wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, gen_count, pop_count
    );

    modport slave (
        input  frame_tick, run, step, frame_div, load, clear,
               wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, busy, gen_count, pop_count
    );
endinterface

// File: rtl/life_gen_engine_neighbour.sv
// Live-neighbour count (0..8) of one cell; edges are dead or toroidal depending on WRAP.
module life_neighbour_count #(
    parameter int BIT_W = 3,
    parameter int BIT_H = 3,
    parameter int WRAP  = 0
) (
    input  logic [(1 << (BIT_W + BIT_H))-1:0] cur,
    input  logic [BIT_W+BIT_H-1:0]            idx,
    output logic [3:0]                        n
);
    localparam int AW = BIT_W + BIT_H;
    localparam int W  = 1 << BIT_W;
    localparam int H  = 1 << BIT_H;

    logic [BIT_W-1:0] x_s;
    logic [BIT_H-1:0] y_s;
    int               nx_s;
    int               ny_s;
    logic             in_s;
    logic [AW-1:0]    cell_s;

    assign x_s = idx[BIT_W-1:0];
    assign y_s = idx[AW-1:BIT_W];

    // Sum the eight surrounding cells, dropping or folding off-board coordinates
    always_comb begin
        n      = 4'd0;
        nx_s   = 0;
        ny_s   = 0;
        in_s   = 1'b0;
        cell_s = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx_s = int'(x_s) + dx;
                ny_s = int'(y_s) + dy;
                if (WRAP != 0) begin
                    nx_s = (nx_s + W) % W;
                    ny_s = (ny_s + H) % H;
                    in_s = 1'b1;
                end else begin
                    in_s = (nx_s >= 0) && (nx_s < W) && (ny_s >= 0) && (ny_s < H);
                end
                cell_s = AW'(ny_s * W + nx_s);
                if (in_s && !(dx == 0 && dy == 0)) begin
                    n = n + {3'b000, cur[cell_s]};
                end else begin
                    n = n;
                end
            end
        end
    end
endmodule

// File: rtl/life_gen_engine.sv
// Double-buffered Game of Life board: evaluates one cell per clock in vblank,
// then commits the whole new generation in a single cycle.
module life_gen_engine
    import life_pkg::*;
#(
    parameter int          BIT_W        = life_pkg::BIT_W,
    parameter int          BIT_H        = life_pkg::BIT_H,
    parameter int          WRAP         = 0,
    parameter logic [63:0] INIT_PATTERN = life_pkg::INIT_PATTERN
) (
    input logic                clk,
    input logic                rst_n,
    life_gen_engine_if.slave   bus
);
    localparam int AW    = BIT_W + BIT_H;
    localparam int CELLS = 1 << AW;
    localparam logic [CELLS-1:0] INIT_CUR = INIT_PATTERN[CELLS-1:0];
    localparam logic [AW:0]      INIT_CNT = (AW+1)'(popcount64(64'(INIT_CUR)));

    state_e           state_q, state_d;
    logic [CELLS-1:0] cur_q, cur_d;
    logic [CELLS-1:0] nxt_q, nxt_d;
    logic [AW-1:0]    k_q, k_d;
    logic [AW:0]      acc_q, acc_d;
    logic [15:0]      gen_q, gen_d;
    logic [AW:0]      pop_q, pop_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic             pend_q, pend_d;
    logic             step_prev_q, step_prev_d;
    logic             run_prev_q, run_prev_d;

    logic [3:0]       n_s;
    logic             cell_next_s;
    logic             go_s;
    logic             step_rise_s;
    logic             run_rise_s;

    life_neighbour_count #(
        .BIT_W (BIT_W),
        .BIT_H (BIT_H),
        .WRAP  (WRAP)
    ) u_nbr (
        .cur (cur_q),
        .idx (k_q),
        .n   (n_s)
    );

    assign cell_next_s = life_rule(cur_q[k_q], n_s);
    assign step_rise_s = bus.step & ~step_prev_q;
    assign run_rise_s  = bus.run & ~run_prev_q;

    assign bus.rd_data   = cur_q[bus.rd_addr];
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.gen_count = gen_q;
    assign bus.pop_count = pop_q;

    // Next-state, trigger, board edit and evaluation datapath
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        k_d         = k_q;
        acc_d       = acc_q;
        gen_d       = gen_q;
        pop_d       = pop_q;
        fcnt_d      = fcnt_q;
        pend_d      = pend_q;
        step_prev_d = bus.step;
        run_prev_d  = bus.run;
        go_s        = 1'b0;

        // A step edge only arms a generation in single-step mode
        if (run_rise_s) begin
            pend_d = 1'b0;
        end else if (step_rise_s && !bus.run) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.frame_tick) begin
                    if (bus.run) begin
                        if (fcnt_q == bus.frame_div) begin
                            go_s   = 1'b1;
                            fcnt_d = 2'd0;
                        end else begin
                            fcnt_d = fcnt_q + 2'd1;
                        end
                    end else begin
                        go_s = pend_q;
                    end
                end else begin
                    go_s = 1'b0;
                end

                if (go_s) begin
                    state_d = ST_EVAL;
                    k_d     = '0;
                    acc_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end

                if (bus.load) begin
                    cur_d = INIT_CUR;
                    pop_d = INIT_CNT;
                end else if (bus.clear) begin
                    cur_d = '0;
                    pop_d = '0;
                end else if (bus.wr_en) begin
                    cur_d[bus.wr_addr] = bus.wr_data;
                    if (cur_q[bus.wr_addr] != bus.wr_data) begin
                        if (bus.wr_data) begin
                            pop_d = pop_q + (AW+1)'(1);
                        end else begin
                            pop_d = pop_q - (AW+1)'(1);
                        end
                    end else begin
                        pop_d = pop_q;
                    end
                end else begin
                    cur_d = cur_q;
                end
            end

            ST_EVAL: begin
                nxt_d[k_q] = cell_next_s;
                acc_d      = acc_q + (AW+1)'(cell_next_s);
                k_d        = k_q + AW'(1);
                if (k_q == AW'(CELLS - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_EVAL;
                end
            end

            ST_COMMIT: begin
                cur_d   = nxt_q;
                gen_d   = gen_q + 16'd1;
                pop_d   = acc_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and board registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_q       <= INIT_CUR;
            nxt_q       <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            gen_q       <= 16'd0;
            pop_q       <= INIT_CNT;
            fcnt_q      <= 2'd0;
            pend_q      <= 1'b0;
            step_prev_q <= 1'b0;
            run_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            gen_q       <= gen_d;
            pop_q       <= pop_d;
            fcnt_q      <= fcnt_d;
            pend_q      <= pend_d;
            step_prev_q <= step_prev_d;
            run_prev_q  <= run_prev_d;
        end
    end
endmodule

// File: doc/life_gen_engine.md
Name: life_gen_engine

Overview:
Clocked generation engine for the Game of Life demo. It holds the displayed board and computes the next generation one cell per clock during vertical blanking, double-buffered so the display never tears. It sits directly upstream of the pixel renderer: the renderer drives rd_addr from beam position and consumes rd_data; frame_tick comes from vga_sync at vblank start. It replaces per-vsync-edge board logic with a single-clock design.

Parameters:
BIT_W, 3, log2 of board width in cells
BIT_H, 3, log2 of board height in cells
WRAP, 0, 0 = cells beyond the edge are dead; 1 = toroidal wrap
INIT_PATTERN, 64'h50A8_8888_0609_0909, reset/load board (bit i = cell i), population 17

Ports:
clk  in  1  pixel clock, the single clock
rst_n  in  1  reset, synchronous, active-low
frame_tick  in  1  one-cycle pulse at the start of vertical blanking
run  in  1  1 = free-running generations
step  in  1  level; its rising edge requests one generation while run=0
frame_div  in  2  in run mode, one generation every frame_div+1 ticks
load  in  1  pulse; restore INIT_PATTERN
clear  in  1  pulse; zero the board
wr_en  in  1  cell write strobe
wr_addr  in  BIT_W+BIT_H  cell index written
wr_data  in  1  cell value written
rd_addr  in  BIT_W+BIT_H  renderer read index
rd_data  out  1  cur[rd_addr], combinational
busy  out  1  high in EVAL and COMMIT
gen_count  out  16  generations committed since reset; wraps at 0xFFFF->0
pop_count  out  BIT_W+BIT_H+1  live cells on the displayed board

Behaviour:
- Indexing: SIZE=2^(BIT_W+BIT_H); idx = y*W + x; x=idx[BIT_W-1:0]; y=idx[BIT_W+BIT_H-1:BIT_W].
- Reset (rst_n=0 at clk edge), any state including mid-EVAL:
  - cur=INIT_PATTERN; nxt=0; state IDLE; busy=0; gen_count=0; pop_count=17 (popcount of INIT_PATTERN).
  - frame counter=0; step pending=0; step edge-detect register=0.
- Board registers: cur (displayed) and nxt (scratch). rd_data reads only cur.
- States:
  - IDLE -> EVAL on a cycle with frame_tick=1 and trigger true; cell index k=0.
  - EVAL: each cycle nxt[k] = rule(cur[k], n(k)); pop accumulator += nxt[k]; k++. Lasts exactly SIZE cycles.
  - COMMIT (1 cycle): cur<=nxt; gen_count++; pop_count<=accumulator; -> IDLE.
  - busy is high for exactly SIZE+1 cycles per generation. New cur is visible on rd_data the cycle after COMMIT.
- Rule: alive' = (alive && n in {2,3}) || (!alive && n==3). n is a 0..8 count of the eight neighbours; out-of-board neighbours are dead if WRAP=0, taken modulo W/H if WRAP=1.
- Trigger, evaluated only on frame_tick in IDLE:
  - run=1: frame counter increments per tick; when it equals frame_div, generate and counter<=0.
  - run=0: generate if step pending; pending is cleared on entering EVAL.
- Step pending: set by a step rising edge while run=0. Ignored while run=1. Cleared when run rises.
- frame_tick while busy: ignored; frame counter unchanged.
- In IDLE only (all ignored while busy), priority load > clear > wr_en:
  - load: cur=INIT_PATTERN, pop_count=17.
  - clear: cur=0, pop_count=0.
  - wr_en: cur[wr_addr]=wr_data; pop_count adjusted +/-1 only if the value changes.
- Edits never alter gen_count.
- Timing budget: SIZE+1 cycles must fit in vblank (45 lines x 800 clocks); a 64-cell board uses 65 cycles.

Decomposition:
- Package life_pkg: BIT_W, BIT_H, SIZE, INIT_PATTERN, INIT_POP=17, state encoding (IDLE, EVAL, COMMIT).
- Sub-module life_neighbour_count: combinational; inputs cur, index, WRAP; output n[3:0]. Instantiated once, addressed by k.

Test Plan:
- Reset -> rd_data=1 at addr 0,3,60; rd_data=0 at addr 1,63; pop_count=17; gen_count=0; busy=0.
- clear, write 26,27,28=1, step rise, frame_tick -> busy high 65 cycles; then 19,27,35 alive, all others dead; pop_count=3; gen_count=1.
- Same blinker, run=1, frame_div=2, 6 ticks -> generations after ticks 3 and 6; board back to horizontal; gen_count=2.
- WRAP=0: cells 0,1,2 alive, one step -> only 1 and 9 alive; pop_count=2. WRAP=1: cells 7,0,1, one step -> cells 56,0,8 alive.
- During busy: frame_tick, wr_en to 63, load, and a step edge with run=1 -> all ignored; cur unchanged and no extra generation follows.
- rst_n=0 at EVAL cycle 30 -> next cycle: IDLE, busy=0, cur=INIT_PATTERN, gen_count=0, pop_count=17.
